// File: rtl/spi_debug_pkg.sv
// Shared definitions for the SPI debug host and the target-side spi_debug_ifc.
// Frame layout is waddr[15:0] then wdata[15:0], MSB first.
package spi_debug_pkg;

    localparam int FRAME_BITS = 32;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;

    localparam logic [15:0] CTRL_ADDR   = 16'hF000;
    localparam logic [3:0]  REGION_SRAM = 4'h0;
    localparam logic [3:0]  REGION_VRAM = 4'h8;
    localparam logic [3:0]  REGION_CTRL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: reloads to CLKDIV-1 on load and flags tick once CLKDIV cycles
// have elapsed since the last load.
module spi_phase_timer #(
    parameter int CLKDIV = 2,
    parameter int CNT_W  = $clog2(CLKDIV + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(CLKDIV - 1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/spi_debug_host.sv
// SPI mode-0 initiator that sends 32-bit debug write frames and returns the
// MISO bits of the data half as a read-back word.
module spi_debug_host
    import spi_debug_pkg::*;
#(
    parameter int CLKDIV = 2,
    parameter int CNT_W  = $clog2(CLKDIV + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                spi_clk_o,
    output logic                spi_cs_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i
);

    state_t state, state_d;

    // tx_sr holds only the bits not yet on MOSI; the frame MSB goes out at accept.
    logic [FRAME_BITS-2:0] tx_sr, tx_d;
    logic [DATA_W-1:0]     rx_sr, rx_d;
    logic [4:0]            bitcnt, bit_d;
    logic                  busy_d, done_d, sck_d, cs_d, mosi_d;
    logic [DATA_W-1:0]     rdata_d;
    logic                  accept, load, tick;

    assign accept = (state == IDLE) && req_i && !busy_o;
    assign load   = (state == IDLE) ? accept : tick;

    spi_phase_timer #(
        .CLKDIV (CLKDIV),
        .CNT_W  (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bitcnt     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            spi_clk_o  <= 1'b0;
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            state      <= state_d;
            tx_sr      <= tx_d;
            rx_sr      <= rx_d;
            bitcnt     <= bit_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            rdata_o    <= rdata_d;
            spi_clk_o  <= sck_d;
            spi_cs_o   <= cs_d;
            spi_mosi_o <= mosi_d;
        end
    end

    always_comb begin
        state_d = state;
        tx_d    = tx_sr;
        rx_d    = rx_sr;
        bit_d   = bitcnt;
        busy_d  = busy_o;
        done_d  = 1'b0;
        rdata_d = rdata_o;
        sck_d   = spi_clk_o;
        cs_d    = spi_cs_o;
        mosi_d  = spi_mosi_o;

        case (state)
            IDLE: begin
                if (accept) begin
                    tx_d    = {waddr_i[ADDR_W-2:0], wdata_i};
                    cs_d    = 1'b0;
                    mosi_d  = waddr_i[ADDR_W-1];
                    busy_d  = 1'b1;
                    bit_d   = 5'(FRAME_BITS - 1);
                    state_d = LOW;
                end
            end
            // Only the last 16 samples survive in rx_sr, so address-phase MISO drops out.
            LOW: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_sr[DATA_W-2:0], spi_miso_i};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bitcnt != 5'd0) begin
                        tx_d    = {tx_sr[FRAME_BITS-3:0], 1'b0};
                        mosi_d  = tx_sr[FRAME_BITS-2];
                        bit_d   = bitcnt - 5'd1;
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = rx_sr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_debug_host.sv
// Bench for spi_debug_host: one instance at CLKDIV=2 and one at CLKDIV=1, each
// with a small SPI target model that records completed write frames.
module tb_spi_debug_host;
    import spi_debug_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_a = 1'b0, busy_a, done_a, sck_a, cs_a, mosi_a, miso_a = 1'b0;
    logic [15:0] waddr_a = '0, wdata_a = '0, rdata_a;
    logic        req_b = 1'b0, busy_b, done_b, sck_b, cs_b, mosi_b;
    logic [15:0] waddr_b = '0, wdata_b = '0, rdata_b;

    spi_debug_host #(.CLKDIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_i(req_a), .waddr_i(waddr_a), .wdata_i(wdata_a),
        .busy_o(busy_a), .done_o(done_a), .rdata_o(rdata_a), .spi_clk_o(sck_a),
        .spi_cs_o(cs_a), .spi_mosi_o(mosi_a), .spi_miso_i(miso_a)
    );

    spi_debug_host #(.CLKDIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_i(req_b), .waddr_i(waddr_b), .wdata_i(wdata_b),
        .busy_o(busy_b), .done_o(done_b), .rdata_o(rdata_b), .spi_clk_o(sck_b),
        .spi_cs_o(cs_b), .spi_mosi_o(mosi_b), .spi_miso_i(1'b0)
    );

    // Target model A: captures MOSI on SCK rise, shifts MISO out on SCK fall.
    logic [31:0] pat_a = '0, rx_a = '0;
    logic        cs_q_a = 1'b1, sck_q_a = 1'b0;
    int          rises_a = 0, cs_low_a = 0, hi_cnt_a = 0, gap_a = 0, done_cnt_a = 0;
    logic [31:0] writes_a[$];

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (!cs_a && cs_q_a) begin
            rises_a  = 0;
            cs_low_a = 0;
            rx_a     = '0;
            gap_a    = hi_cnt_a;
            miso_a   = pat_a[31];
        end
        if (cs_a && !cs_q_a && rises_a == 32) writes_a.push_back(rx_a);
        if (cs_a) hi_cnt_a = cs_q_a ? hi_cnt_a + 1 : 1;
        else cs_low_a++;
        if (!cs_a && sck_a && !sck_q_a) begin
            rx_a = {rx_a[30:0], mosi_a};
            rises_a++;
        end
        if (!cs_a && !sck_a && sck_q_a && rises_a < 32) miso_a = pat_a[31 - rises_a];
        cs_q_a  = cs_a;
        sck_q_a = sck_a;
    end

    // Target model B: records frames and latches the CPU-hold control bit.
    logic [31:0] rx_b = '0;
    logic        cs_q_b = 1'b1, sck_q_b = 1'b0, ctrl_b = 1'b0;
    int          bits_b = 0;
    logic [31:0] writes_b[$];

    always @(negedge clk) begin
        if (!cs_b && cs_q_b) begin
            bits_b = 0;
            rx_b   = '0;
        end
        if (cs_b && !cs_q_b && bits_b == 32) begin
            writes_b.push_back(rx_b);
            if (rx_b[31:16] == CTRL_ADDR) ctrl_b = rx_b[0];
        end
        if (!cs_b && sck_b && !sck_q_b) begin
            rx_b = {rx_b[30:0], mosi_b};
            bits_b++;
        end
        cs_q_b  = cs_b;
        sck_q_b = sck_b;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] pat;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic applyStimulus(input vec_t v);
        int  e0;
        int  dcyc;
        bit  found;
        @(negedge clk);
        pat_a   = v.pat;
        waddr_a = v.addr;
        wdata_a = v.data;
        req_a   = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        req_a   = 1'b0;
        e0      = cyc;
        waddr_a = ~v.addr;
        wdata_a = ~v.data;
        found   = 1'b0;
        dcyc    = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk); #1;
            if (done_a) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
        checkOutput("done seen", 32'(found), 32'd1);
        checkOutput("done latency", dcyc - e0, 132);
        checkOutput("rdata", 32'(rdata_a), 32'(v.rdata));
        checkOutput("busy at done", 32'(busy_a), 32'd0);
        checkOutput("mosi word", rx_a, {v.addr, v.data});
        checkOutput("sck rises", rises_a, 32);
        checkOutput("cs low cycles", cs_low_a, 130);
        @(negedge clk); #1;
        checkOutput("done width", 32'(done_a), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  bad;
        int  e0;
        int  d1;
        int  d2;
        int  dc0;
        int  nw0;
        bit  found;
        logic [31:0] w0, w1;

        vecs[0] = '{16'h8005, 16'h00AB, 32'hFFFF_A5A5, 16'hA5A5};
        vecs[1] = '{16'h0000, 16'hFFFF, 32'h0000_0000, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 32'h0000_5A5A, 16'h5A5A};
        vecs[3] = '{16'hF000, 16'h0001, 32'h1234_8001, 16'h8001};
        vecs[4] = '{16'h2468, 16'h1357, 32'h0000_C3C3, 16'hC3C3};

        // Reset state and idle hold.
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset cs", 32'(cs_a), 32'd1);
        checkOutput("reset sck", 32'(sck_a), 32'd0);
        checkOutput("reset mosi", 32'(mosi_a), 32'd0);
        checkOutput("reset busy", 32'(busy_a), 32'd0);
        checkOutput("reset done", 32'(done_a), 32'd0);
        checkOutput("reset rdata", 32'(rdata_a), 32'd0);
        checkOutput("reset cs b", 32'(cs_b), 32'd1);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (cs_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0 || busy_a !== 1'b0 ||
                done_a !== 1'b0 || rdata_a !== 16'h0) bad++;
        end
        checkOutput("idle hold bad cycles", bad, 0);

        // Directed frames at CLKDIV=2.
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Back-to-back frames with req held high.
        writes_a.delete();
        pat_a = '0;
        @(negedge clk);
        waddr_a = 16'h0010;
        wdata_a = 16'h1234;
        req_a   = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        e0      = cyc;
        waddr_a = 16'h0011;
        wdata_a = 16'h5678;
        found = 1'b0;
        d1    = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk); #1;
            if (done_a) begin
                found = 1'b1;
                d1    = cyc;
            end
        end
        checkOutput("b2b first latency", d1 - e0, 132);
        @(negedge clk); #1;
        checkOutput("b2b second accept", {30'd0, busy_a, cs_a}, 32'd2);
        req_a = 1'b0;
        found = 1'b0;
        d2    = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk); #1;
            if (done_a) begin
                found = 1'b1;
                d2    = cyc;
            end
        end
        checkOutput("b2b second latency", d2 - d1, 133);
        checkOutput("b2b cs gap", gap_a, 3);
        checkOutput("b2b write count", writes_a.size(), 2);
        w0 = (writes_a.size() > 0) ? writes_a[0] : 32'hDEAD_DEAD;
        w1 = (writes_a.size() > 1) ? writes_a[1] : 32'hDEAD_DEAD;
        checkOutput("b2b write 0", w0, 32'h0010_1234);
        checkOutput("b2b write 1", w1, 32'h0011_5678);
        repeat (10) @(negedge clk);
        #1 checkOutput("b2b no third frame", 32'(busy_a), 32'd0);

        // Reset asserted at the 10th SCK rise.
        dc0 = done_cnt_a;
        nw0 = writes_a.size();
        @(negedge clk);
        pat_a   = '0;
        waddr_a = 16'h1357;
        wdata_a = 16'h2468;
        req_a   = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        req_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (rises_a == 10) found = 1'b1;
        end
        checkOutput("reached 10th rise", 32'(found), 32'd1);
        checkOutput("sck high before reset", 32'(sck_a), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset cs", 32'(cs_a), 32'd1);
        checkOutput("async reset sck", 32'(sck_a), 32'd0);
        checkOutput("async reset busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        #1;
        checkOutput("no done after abort", done_cnt_a - dc0, 0);
        checkOutput("aborted frame not recorded", writes_a.size() - nw0, 0);
        applyStimulus(vecs[4]);

        // CLKDIV=1 control write with a mid-frame request that must be ignored.
        @(negedge clk);
        waddr_b = CTRL_ADDR;
        wdata_b = 16'h0001;
        req_b   = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        req_b = 1'b0;
        e0    = cyc;
        repeat (20) @(negedge clk);
        #1;
        checkOutput("b busy mid-frame", 32'(busy_b), 32'd1);
        waddr_b = 16'h1111;
        wdata_b = 16'h2222;
        req_b   = 1'b1;
        repeat (5) @(negedge clk);
        #1 req_b = 1'b0;
        found = 1'b0;
        d1    = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #1;
            if (done_b) begin
                found = 1'b1;
                d1    = cyc;
            end
        end
        checkOutput("b done latency", d1 - e0, 66);
        checkOutput("b rdata", 32'(rdata_b), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("b idle after frame", 32'(busy_b), 32'd0);
        checkOutput("b write count", writes_b.size(), 1);
        w0 = (writes_b.size() > 0) ? writes_b[0] : 32'hDEAD_DEAD;
        checkOutput("b control write", w0, 32'hF000_0001);
        checkOutput("b control bit", 32'(ctrl_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
